// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
// Read-side consumer of the asynchronous FIFO, running in the clk_read domain.
// It pops bytes through the FIFO's empty_flag / Read_enable / data_out
// interface, packs PACK consecutive bytes into one word (first byte in
// lane 0, the LSBs) and presents each word on a valid/ready stream.
//
// Ports:
//   clk_read     FIFO read clock, the only clock
//   rst          synchronous, active-high reset
//   empty_flag   FIFO empty indication
//   data_out     FIFO read data, valid one cycle after Read_enable
//   Read_enable  FIFO pop strobe (combinational, never high while empty)
//   m_data       packed output word
//   m_valid      m_data holds a word
//   m_ready      downstream accepts when m_valid && m_ready
//
// Optional feature, macro RD_PACKER_FLUSH_EN:
//   flush        push out the partial word (unused lanes zero)
//   m_bytes      number of valid bytes in m_data
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                       clk_read,
    input  logic                       rst,
    input  logic                       empty_flag,
    input  logic [DATA_WIDTH-1:0]      data_out,
    output logic                       Read_enable,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic                       m_valid,
    input  logic                       m_ready
`ifdef RD_PACKER_FLUSH_EN
    ,
    input  logic                       flush,
    output logic [$clog2(PACK+1)-1:0]  m_bytes
`endif
);

    localparam int CW = $clog2(PACK + 1);
    localparam int W  = DATA_WIDTH * PACK;
    localparam logic [CW:0]   PACK_X = (CW + 1)'(PACK);
    localparam logic [CW-1:0] PACK_C = CW'(PACK);

    logic [W-1:0]  asm_q, asm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rd_pend_q, rd_pend_d;
    logic [W-1:0]  m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;

    logic          rd_en;
    logic          xfer;
    logic          emit;
    logic          out_free;
    logic          fill_room;

`ifdef RD_PACKER_FLUSH_EN
    typedef enum logic {FILL, FLUSH_WAIT} state_e;
    state_e        state_q, state_d;
    logic [CW-1:0] m_bytes_q, m_bytes_d;
    logic          flush_go;
`endif

    always_comb begin
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;

        out_free  = !m_valid_q || m_ready;
        // Bytes held plus the one in flight; the extra bit keeps PACK+1 representable.
        fill_room = ({1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q}) < PACK_X;

`ifdef RD_PACKER_FLUSH_EN
        state_d   = state_q;
        m_bytes_d = m_bytes_q;
        xfer      = (state_q == FILL) && (cnt_q == PACK_C) && out_free;
        // Flush completes only once the in-flight byte has landed.
        flush_go  = (state_q == FLUSH_WAIT) && !rd_pend_q && out_free;
        if ((state_q == FILL) && flush && !xfer && ((cnt_q != '0) || rd_pend_q))
            state_d = FLUSH_WAIT;
        if (flush_go)
            state_d = FILL;
        emit  = xfer || (flush_go && (cnt_q != '0));
        rd_en = !rst && !empty_flag && (state_q == FILL) && (fill_room || xfer);
`else
        xfer  = (cnt_q == PACK_C) && out_free;
        emit  = xfer;
        rd_en = !rst && !empty_flag && (fill_room || xfer);
`endif

        rd_pend_d = rd_en;

        // Capture the byte popped last cycle into lane cnt.
        if (rd_pend_q) begin
            for (int i = 0; i < PACK; i++) begin
                if (cnt_q == CW'(i))
                    asm_d[i*DATA_WIDTH +: DATA_WIDTH] = data_out;
            end
            cnt_d = cnt_q + CW'(1);
        end

        // Emit never coincides with a capture (rd_pend is 0 when full or
        // flushing), so clearing asm here cannot drop a byte. Clearing keeps
        // unused lanes of a flushed partial word at zero.
        if (emit) begin
            m_data_d  = asm_q;
            m_valid_d = 1'b1;
            cnt_d     = '0;
            asm_d     = '0;
`ifdef RD_PACKER_FLUSH_EN
            m_bytes_d = cnt_q;
`endif
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_read) begin
        if (rst) begin
            asm_q     <= '0;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
`ifdef RD_PACKER_FLUSH_EN
            state_q   <= FILL;
            m_bytes_q <= '0;
`endif
        end else begin
            asm_q     <= asm_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
`ifdef RD_PACKER_FLUSH_EN
            state_q   <= state_d;
            m_bytes_q <= m_bytes_d;
`endif
        end
    end

    assign Read_enable = rd_en;
    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
`ifdef RD_PACKER_FLUSH_EN
    assign m_bytes     = m_bytes_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a byte-FIFO model feeds the DUT,
// a negedge monitor logs reads and accepted words, checks use immediate
// assertions. Build with RD_PACKER_FLUSH_EN to exercise flush.
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int CW = $clog2(PK + 1);

    logic          clk_read = 1'b0;
    logic          rst = 1'b1;
    logic          empty_flag;
    logic [DW-1:0] data_out = '0;
    logic          Read_enable;
    logic [DW*PK-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
`ifdef RD_PACKER_FLUSH_EN
    logic          flush = 1'b0;
    logic [CW-1:0] m_bytes;
`endif

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .clk_read    (clk_read),
        .rst         (rst),
        .empty_flag  (empty_flag),
        .data_out    (data_out),
        .Read_enable (Read_enable),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
`ifdef RD_PACKER_FLUSH_EN
        ,
        .flush       (flush),
        .m_bytes     (m_bytes)
`endif
    );

    always #5 clk_read = ~clk_read;

    // FIFO model: tail advanced by the stimulus, head by pops.
    logic [DW-1:0] mem [0:127];
    int head = 0;
    int tail = 0;
    assign empty_flag = (head == tail);

    always @(posedge clk_read) begin
        if (Read_enable && (head != tail)) begin
            data_out <= mem[head[6:0]];
            head     <= head + 1;
        end
    end

    // Monitor
    int cyc = 0;
    int rd_cnt = 0;
    int viol = 0;
    int vcyc = 0;
    int nw = 0;
    logic [DW*PK-1:0] words [0:63];
    int wcyc [0:63];
`ifdef RD_PACKER_FLUSH_EN
    logic [CW-1:0] wbytes [0:63];
    int fw_rd = 0;
    int fw_cyc = 0;
`endif

    always @(posedge clk_read) cyc <= cyc + 1;

    always @(negedge clk_read) begin
        if (!rst) begin
            if (Read_enable) rd_cnt++;
            if (Read_enable && empty_flag) viol++;
            if (m_valid) vcyc++;
            if (m_valid && m_ready && nw < 64) begin
                words[nw] = m_data;
                wcyc[nw]  = cyc;
`ifdef RD_PACKER_FLUSH_EN
                wbytes[nw] = m_bytes;
`endif
                nw++;
            end
`ifdef RD_PACKER_FLUSH_EN
            if (dut.state_q != '0) begin
                fw_cyc++;
                if (Read_enable) fw_rd++;
            end
`endif
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_read);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] b);
        mem[tail[6:0]] = b;
        tail = tail + 1;
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int k = 0;
        while (nw < n && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, 64'(nw >= n), 64'd1);
    endtask

    int r0, v0, w0;

    initial begin
        // Reset state
        tick(3);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_rd_en", 64'(Read_enable), 64'd0);
        rst = 1'b0;

        // Empty FIFO for 20 cycles
        r0 = rd_cnt; v0 = vcyc;
        tick(20);
        chk("empty_reads", 64'(rd_cnt - r0), 64'd0);
        chk("empty_valid", 64'(vcyc - v0), 64'd0);

        // Basic pack
        r0 = rd_cnt; v0 = vcyc; w0 = nw;
        push(8'h08); push(8'h09); push(8'h0A); push(8'h0B);
        wait_words(w0 + 1, 20, "basic_timeout");
        chk("basic_word", 64'(words[w0]), 64'h0B0A0908);
        tick(5);
        chk("basic_reads", 64'(rd_cnt - r0), 64'd4);
        chk("basic_vcyc", 64'(vcyc - v0), 64'd1);
        chk("basic_nwords", 64'(nw - w0), 64'd1);

        // Stream 32 bytes
        r0 = rd_cnt; w0 = nw;
        for (int i = 0; i < 32; i++) push(8'(i));
        wait_words(w0 + 8, 80, "stream_timeout");
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'(4 * i);
            chk($sformatf("stream_w%0d", i), 64'(words[w0+i]),
                64'({b + 8'd3, b + 8'd2, b + 8'd1, b}));
        end
        for (int i = 1; i < 8; i++)
            chk($sformatf("stream_gap%0d", i), 64'(wcyc[w0+i] - wcyc[w0+i-1]), 64'd5);
        tick(3);
        chk("stream_reads", 64'(rd_cnt - r0), 64'd32);

        // Backpressure
        m_ready = 1'b0;
        r0 = rd_cnt; w0 = nw;
        for (int i = 0; i < 12; i++) push(8'h30 + 8'(i));
        tick(30);
        chk("bp_reads", 64'(rd_cnt - r0), 64'd8);
        chk("bp_rd_en", 64'(Read_enable), 64'd0);
        chk("bp_valid", 64'(m_valid), 64'd1);
        chk("bp_data", 64'(m_data), 64'h33323130);
        tick(5);
        chk("bp_data_hold", 64'(m_data), 64'h33323130);
        m_ready = 1'b1;
        wait_words(w0 + 3, 40, "bp_timeout");
        chk("bp_w0", 64'(words[w0]),   64'h33323130);
        chk("bp_w1", 64'(words[w0+1]), 64'h37363534);
        chk("bp_w2", 64'(words[w0+2]), 64'h3B3A3938);

        // Reset mid-word
        tick(4);
        push(8'h50); push(8'h51);
        tick(6);
        chk("mid_cnt_before", 64'(dut.cnt_q), 64'd2);
        rst = 1'b1;
        tick(1);
        chk("mid_valid", 64'(m_valid), 64'd0);
        chk("mid_cnt", 64'(dut.cnt_q), 64'd0);
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        #1;
        chk("mid_rd_en_in_rst", 64'(Read_enable), 64'd0);
        tick(1);
        rst = 1'b0;
        w0 = nw;
        wait_words(w0 + 1, 20, "mid_timeout");
        chk("mid_word", 64'(words[w0]), 64'hA3A2A1A0);

`ifdef RD_PACKER_FLUSH_EN
        // Flush a 3-byte partial word
        tick(4);
        w0 = nw;
        push(8'h11); push(8'h22); push(8'h33);
        tick(8);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        wait_words(w0 + 1, 20, "flush_timeout");
        chk("flush_word", 64'(words[w0]), 64'h00332211);
        chk("flush_bytes", 64'(wbytes[w0]), 64'd3);
        chk("flush_wait_seen", 64'(fw_cyc > 0), 64'd1);
        chk("flush_wait_reads", 64'(fw_rd), 64'd0);
`endif

        tick(2);
        chk("no_read_when_empty", 64'(viol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d want finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
